// File: rtl/bcd_seg_display_seq.sv
// rtl/bcd_seg_display_seq.sv - sequential double-dabble BCD converter driving DIGITS active-low 7-segment digits
// Optional build macro: LEADING_ZERO_BLANK_EN (blank digits above the most significant non-zero digit).
module bcd_seg_display_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_SHIFT = CNTW'(WIDTH - 1);

  // The digit count must be able to hold the largest input value
  if (10**DIGITS <= 2**WIDTH - 1) begin : g_param_check
    $error("bcd_seg_display_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [BCDW-1:0]     bcd_q, bcd_d;
  logic [BCDW-1:0]     adj;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  // Active-low {g,f,e,d,c,b,a}; nibbles above 9 cannot occur and show blank
  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0011000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Full display image for a BCD word; also used for the reset image (BCD zero)
  function automatic logic [7*DIGITS-1:0] render(input logic [BCDW-1:0] bcd);
    logic [7*DIGITS-1:0] s;
`ifdef LEADING_ZERO_BLANK_EN
    logic seen;
    seen = 1'b0;
`endif
    s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      s[7*i +: 7] = dec7(bcd[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen && i != 0) s[7*i +: 7] = 7'b1111111;
`endif
    end
    return s;
  endfunction

  // Next-state logic: capture, add-3/shift per bit, then publish the digits once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    seg_d   = seg_q;
    adj     = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = value;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Nibbles are corrected independently; the shift carries between them
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == LAST_SHIFT) begin
          state_d = S_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        seg_d   = render(bcd_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any conversion silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= render('0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_seg_display_seq.sv
// tb/tb_bcd_seg_display_seq.sv - randomized self-checking bench for bcd_seg_display_seq against a decimal model
module tb_bcd_seg_display_seq;

  localparam int W = 5;
  localparam int D = 2;
  localparam int SEGW = 7 * D;

  localparam logic [6:0] LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    value = '0;
  logic            busy;
  logic            done;
  logic [SEGW-1:0] seg;

  int n_chk = 0;
  int n_pass = 0;
  logic [SEGW-1:0] exp_seg;

  bcd_seg_display_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // Expected display for an integer, from its decimal digits
  function automatic logic [SEGW-1:0] seg_of(input int v);
    logic [SEGW-1:0] s;
    int p;
    p = 1;
    for (int i = 0; i < D; i++) begin
      s[7*i +: 7] = LUT[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) s[7*i +: 7] = 7'b1111111;
`endif
      p = p * 10;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One conversion of v; optionally pulse a competing start at cycle offset intr_at
  task automatic convert(input int v, input int intr_at, input int intr_v);
    logic [SEGW-1:0] new_seg;
    new_seg = seg_of(v);
    start = 1'b1;
    value = W'(v);
    @(posedge clk);
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      check($sformatf("busy v=%0d k=%0d", v, k), 64'(busy), 64'(k < W));
      check($sformatf("done v=%0d k=%0d", v, k), 64'(done), 64'(k == W + 1));
      check($sformatf("seg v=%0d k=%0d", v, k), 64'(seg), 64'((k == W + 1) ? new_seg : exp_seg));
      if (k == intr_at) begin
        start = 1'b1;
        value = W'(intr_v);
      end else begin
        start = 1'b0;
        value = W'($urandom);
      end
      if (k < W + 1) @(posedge clk);
    end
    exp_seg = new_seg;
  endtask

  initial begin
    exp_seg = seg_of(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset seg", 64'(seg), 64'(exp_seg));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle done", 64'(done), 64'(0));

    convert(31, -1, 0);
    convert(19, 2, 7);
    convert(7, -1, 0);
    convert(0, W, 31);
    convert(31, 0, 3);
    convert(7, -1, 0);

    // Reset during the third SHIFT cycle: no done, display back to reset image
    start = 1'b1;
    value = W'(22);
    @(posedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_seg = seg_of(0);
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort seg", 64'(seg), 64'(exp_seg));
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      check($sformatf("abort quiet done k=%0d", k), 64'(done), 64'(0));
      check($sformatf("abort quiet seg k=%0d", k), 64'(seg), 64'(exp_seg));
    end

    for (int r = 0; r < 30; r++) begin
      int v;
      int ia;
      v = int'($urandom_range(0, 2**W - 1));
      ia = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W)) : -1;
      convert(v, ia, int'($urandom_range(0, 2**W - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
